// File: rtl/pc_gen_unit_if.sv
// Fetch-request bundle between the PC generator and its environment.
// Handshake: a PC is transferred on every rising clk edge where fetch_valid
// and fetch_ready are both 1. While fetch_valid=1 and fetch_ready=0 the PC
// stays stable; the requester withdraws only through trap, redirect_valid,
// halt_req or reset. fetch_ready may be asserted at any time and does not
// have to wait for fetch_valid.
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Control requests from the pipeline and ready from instruction memory.
    logic             trap;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             halt_req;
    logic             fetch_ready;

    // Fetch request and status produced by the PC generator.
    logic             fetch_valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus_inc;
    logic             misaligned;
    logic [CNT_W-1:0] fetch_count;

    // The PC generator side: it issues the fetch request.
    modport master (
        input  trap,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        input  fetch_ready,
        output fetch_valid,
        output pc,
        output pc_plus_inc,
        output misaligned,
        output fetch_count
    );

    // The environment side: pipeline control plus instruction memory.
    modport slave (
        output trap,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        output fetch_ready,
        input  fetch_valid,
        input  pc,
        input  pc_plus_inc,
        input  misaligned,
        input  fetch_count
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator.
// Holds the architectural fetch PC and advances it by INC on each accepted
// fetch. Trap and branch redirects take priority over halting and
// sequential advance. A redirect to a target that is not INC-aligned goes to
// TRAP_VECTOR instead and raises a one-cycle misaligned pulse.
// The FSM state is exposed on the state output for observation.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter int              INC          = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    pc_gen_if.master   bus,
    output logic [1:0] state
);
    // FSM encoding
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // INC is a power of two, so alignment is a mask on the low bits.
    localparam logic [XLEN-1:0] INC_STEP = XLEN'(INC);
    localparam logic [XLEN-1:0] INC_MASK = XLEN'(INC - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             valid_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic             mis_q;
    logic             mis_d;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             target_misaligned;

    // A fetch completes when the registered request meets memory ready.
    assign accept            = valid_q && bus.fetch_ready;
    assign target_misaligned = (bus.redirect_pc & INC_MASK) != '0;

    // Next state, next PC and misaligned pulse, in priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        if (bus.trap) begin
            pc_d    = TRAP_VECTOR;
            state_d = S_RUN;
        end else if (bus.redirect_valid) begin
            state_d = S_RUN;
            if (target_misaligned) begin
                pc_d  = TRAP_VECTOR;
                mis_d = 1'b1;
            end else begin
                pc_d = bus.redirect_pc;
            end
        end else begin
            case (state_q)
                S_BOOT: begin
                    // Single bubble cycle; halt may still be requested here.
                    state_d = bus.halt_req ? S_HALT : S_RUN;
                end
                S_RUN: begin
                    if (bus.halt_req) begin
                        state_d = S_HALT;
                    end else if (accept) begin
                        // Sequential advance, wrapping modulo 2^XLEN.
                        pc_d = pc_q + INC_STEP;
                    end
                end
                S_HALT: begin
                    // Only trap or redirect (handled above) leave HALT.
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    // Registered state, PC, request valid, pulse and fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            valid_q <= 1'b0;
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == S_RUN);
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            // The fetch counts even when a redirect discards the increment.
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fetch_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_q + INC_STEP;
    assign bus.misaligned  = mis_q;
    assign bus.fetch_count = cnt_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Testbench for pc_gen_unit: two instances (INC=4/CNT_W=16 and
// INC=2/CNT_W=4) driven with the same inputs, compared every cycle against
// a behavioural model, plus directed scenarios with fixed expected values.
module tb_pc_gen_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        trap;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_ready;

    pc_gen_if #(.XLEN(32), .CNT_W(16)) ifa ();
    pc_gen_if #(.XLEN(32), .CNT_W(4))  ifb ();
    logic [1:0] state_a;
    logic [1:0] state_b;

    assign ifa.trap           = trap;
    assign ifa.redirect_valid = redirect_valid;
    assign ifa.redirect_pc    = redirect_pc;
    assign ifa.halt_req       = halt_req;
    assign ifa.fetch_ready    = fetch_ready;
    assign ifb.trap           = trap;
    assign ifb.redirect_valid = redirect_valid;
    assign ifb.redirect_pc    = redirect_pc;
    assign ifb.halt_req       = halt_req;
    assign ifb.fetch_ready    = fetch_ready;

    pc_gen_unit #(.XLEN(32), .INC(4), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa), .state(state_a));
    pc_gen_unit #(.XLEN(32), .INC(2), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(ifb), .state(state_b));

    // Scoreboard counters
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: mode is "booting", "running" or "halted".
    typedef enum int {M_BOOTING, M_RUNNING, M_HALTED} mode_t;
    mode_t       m_mode [2];
    logic [31:0] m_pc   [2];
    int          m_cnt  [2];
    logic        m_mis  [2];
    int          m_inc  [2] = '{4, 2};
    int          m_cmod [2] = '{65536, 16};

    task automatic model_edge(input int k);
        bit accepted;
        if (rst) begin
            m_mode[k] = M_BOOTING;
            m_pc[k]   = RV;
            m_cnt[k]  = 0;
            m_mis[k]  = 1'b0;
            return;
        end
        accepted = (m_mode[k] == M_RUNNING) && fetch_ready;
        if (accepted) m_cnt[k] = (m_cnt[k] + 1) % m_cmod[k];
        m_mis[k] = 1'b0;
        if (trap) begin
            m_pc[k]   = TV;
            m_mode[k] = M_RUNNING;
        end else if (redirect_valid) begin
            m_mode[k] = M_RUNNING;
            if ((redirect_pc % m_inc[k]) != 0) begin
                m_pc[k]  = TV;
                m_mis[k] = 1'b1;
            end else begin
                m_pc[k] = redirect_pc;
            end
        end else if (m_mode[k] == M_HALTED) begin
            // stays halted, pc held
        end else if (halt_req) begin
            m_mode[k] = M_HALTED;
        end else begin
            if (accepted) m_pc[k] = 32'((64'(m_pc[k]) + 64'(m_inc[k])) % 64'h1_0000_0000);
            m_mode[k] = M_RUNNING;
        end
    endtask

    task automatic compare_dut(input string name, input int k, input logic fv,
                               input logic [31:0] pcv, input logic [31:0] ppi,
                               input logic mis, input logic [15:0] cnt);
        logic [31:0] exp_ppi;
        exp_ppi = 32'((64'(m_pc[k]) + 64'(m_inc[k])) % 64'h1_0000_0000);
        check({name, "_fetch_valid"}, 64'(fv), 64'(m_mode[k] == M_RUNNING));
        check({name, "_pc"}, 64'(pcv), 64'(m_pc[k]));
        check({name, "_pc_plus_inc"}, 64'(ppi), 64'(exp_ppi));
        check({name, "_misaligned"}, 64'(mis), 64'(m_mis[k]));
        check({name, "_fetch_count"}, 64'(cnt), 64'(m_cnt[k]));
    endtask

    // One clock: inputs already set, update model at the edge, sample 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_dut("a", 0, ifa.fetch_valid, ifa.pc, ifa.pc_plus_inc, ifa.misaligned, ifa.fetch_count);
        compare_dut("b", 1, ifb.fetch_valid, ifb.pc, ifb.pc_plus_inc, ifb.misaligned,
                    16'(ifb.fetch_count));
    endtask

    task automatic idle_inputs();
        trap           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fetch_ready = 1'b0;
        idle_inputs();
        m_mode = '{M_BOOTING, M_BOOTING};
        m_pc   = '{RV, RV};
        m_cnt  = '{0, 0};
        m_mis  = '{1'b0, 1'b0};

        // Reset for two cycles
        step();
        step();
        check("rst_valid", 64'(ifa.fetch_valid), 64'd0);
        check("rst_pc", 64'(ifa.pc), 64'(RV));
        check("rst_count", 64'(ifa.fetch_count), 64'd0);

        // Free run: one boot bubble, then 0, 4, 8
        rst = 1'b0;
        fetch_ready = 1'b1;
        step();
        check("boot_first_valid", 64'(ifa.fetch_valid), 64'd1);
        check("boot_first_pc", 64'(ifa.pc), 64'(RV));
        step();
        check("run_pc4", 64'(ifa.pc), 64'h4);
        check("run_count1", 64'(ifa.fetch_count), 64'd1);
        step();
        check("run_pc8", 64'(ifa.pc), 64'h8);

        // Stall for 3 cycles at 0x8
        fetch_ready = 1'b0;
        repeat (3) step();
        check("stall_pc", 64'(ifa.pc), 64'h8);
        check("stall_valid", 64'(ifa.fetch_valid), 64'd1);
        check("stall_count", 64'(ifa.fetch_count), 64'd2);
        fetch_ready = 1'b1;
        step();
        check("unstall_pc", 64'(ifa.pc), 64'hC);

        // Trap beats redirect; fetch still counts
        trap = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        check("trap_pc", 64'(ifa.pc), 64'(TV));
        check("trap_count", 64'(ifa.fetch_count), 64'd4);
        trap = 1'b0;
        step();
        check("redirect_pc", 64'(ifa.pc), 64'h200);
        check("redirect_valid_out", 64'(ifa.fetch_valid), 64'd1);

        // Misaligned target: INC=4 traps, INC=2 accepts
        redirect_pc = 32'h202;
        step();
        check("mis_a_pc", 64'(ifa.pc), 64'(TV));
        check("mis_a_flag", 64'(ifa.misaligned), 64'd1);
        check("mis_b_pc", 64'(ifb.pc), 64'h202);
        check("mis_b_flag", 64'(ifb.misaligned), 64'd0);
        redirect_valid = 1'b0;
        step();
        check("mis_a_pulse_end", 64'(ifa.misaligned), 64'd0);

        // Halt at 0x40 with halt_req toggling
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        halt_req = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            halt_req = 1'($urandom_range(0, 1));
            step();
            check("halt_valid", 64'(ifa.fetch_valid), 64'd0);
            check("halt_pc", 64'(ifa.pc), 64'h40);
        end
        halt_req = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step();
        check("unhalt_pc", 64'(ifa.pc), 64'h80);
        check("unhalt_valid", 64'(ifa.fetch_valid), 64'd1);

        // PC wrap at the top of the address space
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap_ppi", 64'(ifa.pc_plus_inc), 64'h0);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc", 64'(ifa.pc), 64'h0);

        // Reset during a stalled fetch
        fetch_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midrst_valid", 64'(ifa.fetch_valid), 64'd0);
        check("midrst_pc", 64'(ifa.pc), 64'(RV));
        check("midrst_count", 64'(ifa.fetch_count), 64'd0);
        rst = 1'b0;
        fetch_ready = 1'b1;
        step();
        check("midrst_boot_pc", 64'(ifa.pc), 64'(RV));

        // Counter wrap on the 4-bit instance after 16 accepts
        repeat (16) step();
        check("cnt_wrap_b", 64'(ifb.fetch_count), 64'd0);
        check("cnt_nowrap_a", 64'(ifa.fetch_count), 64'd16);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            trap           = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            halt_req       = ($urandom_range(0, 19) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
